// File: rtl/gps_if_sampler.sv
// IF sampler front stage: synchronises the RF front-end's 2-bit samples into correlator_clk,
// with a sample counter, a loss-of-IF-clock watchdog and a raw-sample snapshot buffer.
`timescale 1ns/1ps
module gps_if_sampler #(
   parameter int SYNC_STAGES = 2,
   parameter int WDOG_LIMIT  = 64,
   parameter int SNAP_AW     = 4
) (
   input  logic               correlator_clk,
   input  logic               rstn,
   input  logic               if_clk,
   input  logic               if_sign,
   input  logic               if_mag,
   output logic               sign,
   output logic               mag,
   output logic               sample_en,
   output logic [31:0]        sample_count,
   output logic               clk_lost,
   input  logic               snap_start,
   output logic               snap_busy,
   output logic               snap_done,
   output logic               snap_err,
   input  logic [SNAP_AW-1:0] snap_rd_addr,
   output logic [31:0]        snap_rd_data
);

   localparam int              WD_W       = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX     = WD_W'(WDOG_LIMIT);
   localparam int              DEPTH      = 2 ** SNAP_AW;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] sign_sync;
   logic [SYNC_STAGES-1:0] mag_sync;
   logic                   clk_prev;
   logic                   edge_det;
   logic [WD_W-1:0]        wd;

   logic [1:0]             state;
   logic [3:0]             word_pos;
   logic [SNAP_AW-1:0]     widx;
   logic [31:0]            packer;
   logic                   wr_en;
   logic [31:0]            wr_word;
   logic [31:0]            snap_mem [DEPTH];

   // if_clk is sampled as plain data; the edge is found after the synchroniser
   always_ff @(posedge correlator_clk) begin
      if (!rstn) begin
         clk_sync  <= '0;
         sign_sync <= '0;
         mag_sync  <= '0;
         clk_prev  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], if_clk};
         sign_sync <= {sign_sync[SYNC_STAGES-2:0], if_sign};
         mag_sync  <= {mag_sync[SYNC_STAGES-2:0], if_mag};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign edge_det = clk_sync[SYNC_STAGES-1] & ~clk_prev;

   always_ff @(posedge correlator_clk) begin
      if (!rstn) begin
         sign         <= 1'b0;
         mag          <= 1'b0;
         sample_en    <= 1'b0;
         sample_count <= 32'd0;
      end else begin
         sample_en <= edge_det;
         if (edge_det) begin
            sign         <= sign_sync[SYNC_STAGES-1];
            mag          <= mag_sync[SYNC_STAGES-1];
            sample_count <= sample_count + 32'd1;
         end
      end
   end

   // Saturating idle counter; clk_lost trails wd by one register stage
   always_ff @(posedge correlator_clk) begin
      if (!rstn) begin
         wd       <= '0;
         clk_lost <= 1'b0;
      end else begin
         if (edge_det) begin
            wd <= '0;
         end else if (wd != WD_MAX) begin
            wd <= wd + WD_W'(1);
         end
         clk_lost <= (wd == WD_MAX);
      end
   end

   assign wr_word   = {packer[29:0], sign, mag};
   assign wr_en     = (state == ST_CAPTURE) && sample_en && !clk_lost && (word_pos == 4'd15);
   assign snap_busy = (state == ST_ARM) || (state == ST_CAPTURE);

   // Loss of IF clock takes priority over both new samples and new requests
   always_ff @(posedge correlator_clk) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         word_pos  <= 4'd0;
         widx      <= '0;
         packer    <= 32'd0;
         snap_done <= 1'b0;
         snap_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (snap_start && !clk_lost) begin
                  state     <= ST_ARM;
                  snap_done <= 1'b0;
                  snap_err  <= 1'b0;
                  widx      <= '0;
                  word_pos  <= 4'd0;
               end
            end
            ST_ARM: begin
               if (clk_lost) begin
                  state     <= ST_IDLE;
                  snap_err  <= 1'b1;
                  snap_done <= 1'b0;
               end else if (sample_en) begin
                  state    <= ST_CAPTURE;
                  packer   <= {30'd0, sign, mag};
                  word_pos <= 4'd1;
               end
            end
            ST_CAPTURE: begin
               if (clk_lost) begin
                  state     <= ST_IDLE;
                  snap_err  <= 1'b1;
                  snap_done <= 1'b0;
               end else if (sample_en) begin
                  packer   <= wr_word;
                  word_pos <= word_pos + 4'd1;
                  if (word_pos == 4'd15) begin
                     widx <= widx + SNAP_AW'(1);
                     if (widx == {SNAP_AW{1'b1}}) begin
                        state     <= ST_IDLE;
                        snap_done <= 1'b1;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Buffer contents survive reset; only the read register is cleared
   always_ff @(posedge correlator_clk) begin
      if (wr_en) begin
         snap_mem[widx] <= wr_word;
      end
   end

   always_ff @(posedge correlator_clk) begin
      if (!rstn) begin
         snap_rd_data <= 32'd0;
      end else begin
         snap_rd_data <= snap_mem[snap_rd_addr];
      end
   end

endmodule

// File: tb/tb_gps_if_sampler.sv
// Self-checking bench for gps_if_sampler: drives a model front-end and compares the
// strobes, counter, watchdog and snapshot words against a sample log kept by the bench.
`timescale 1ns/1ps
module tb_gps_if_sampler;

   localparam int SYNC_STAGES = 2;
   localparam int WDOG_LIMIT  = 64;
   localparam int SNAP_AW     = 4;
   localparam int NWORDS      = 2 ** SNAP_AW;
   localparam int DRV_N       = 8192;

   logic               correlator_clk;
   logic               rstn;
   logic               if_clk;
   logic               if_sign;
   logic               if_mag;
   logic               sign;
   logic               mag;
   logic               sample_en;
   logic [31:0]        sample_count;
   logic               clk_lost;
   logic               snap_start;
   logic               snap_busy;
   logic               snap_done;
   logic               snap_err;
   logic [SNAP_AW-1:0] snap_rd_addr;
   logic [31:0]        snap_rd_data;

   int          cmp_count = 0;
   int          err_count = 0;
   logic [1:0]  drv_mem [DRV_N];
   int          drv_widx  = 0;
   int          mon_ridx  = 0;
   logic [31:0] model_cnt = 32'd0;
   bit          pend_cnt  = 1'b0;
   int          force_req = 0;
   int          force_ack = 0;
   bit          if_run    = 1'b0;
   bit          hold_high = 1'b0;
   int          data_mode = 2;

   gps_if_sampler #(
      .SYNC_STAGES(SYNC_STAGES),
      .WDOG_LIMIT (WDOG_LIMIT),
      .SNAP_AW    (SNAP_AW)
   ) dut (
      .correlator_clk(correlator_clk),
      .rstn          (rstn),
      .if_clk        (if_clk),
      .if_sign       (if_sign),
      .if_mag        (if_mag),
      .sign          (sign),
      .mag           (mag),
      .sample_en     (sample_en),
      .sample_count  (sample_count),
      .clk_lost      (clk_lost),
      .snap_start    (snap_start),
      .snap_busy     (snap_busy),
      .snap_done     (snap_done),
      .snap_err      (snap_err),
      .snap_rd_addr  (snap_rd_addr),
      .snap_rd_data  (snap_rd_data)
   );

   initial correlator_clk = 1'b0;
   always #5 correlator_clk = ~correlator_clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      cmp_count++;
      if (actual !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [1:0] pat_sample(input int idx);
      case (idx % 4)
         0:       return 2'b10;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] next_data(input int idx);
      if (data_mode == 1) return pat_sample(idx);
      if (data_mode == 2) return 2'b10;
      return 2'($urandom_range(0, 3));
   endfunction

   // Word w of a snapshot holds samples first+16w .. first+16w+15, sample k at bits [31-2k:30-2k]
   function automatic logic [31:0] model_word(input int first, input int w);
      logic [31:0] word;
      word = 32'd0;
      for (int k = 0; k < 16; k++) begin
         word[31-2*k -: 2] = drv_mem[(first + 16*w + k) % DRV_N];
      end
      return word;
   endfunction

   // Front-end model: 80 ns period (corr/8), data changes on the falling edge
   initial begin
      if_clk = 1'b0;
      {if_sign, if_mag} = 2'b10;
      forever begin
         if (!if_run) begin
            @(negedge correlator_clk);
         end else begin
            if_clk = 1'b1;
            drv_mem[drv_widx % DRV_N] = {if_sign, if_mag};
            drv_widx++;
            #40;
            while (hold_high) @(negedge correlator_clk);
            if_clk = 1'b0;
            {if_sign, if_mag} = next_data(drv_widx);
            #40;
         end
      end
   end

   // Every strobe consumes the next logged sample; the count is checked one cycle later
   always @(negedge correlator_clk) begin
      if (force_req != force_ack) begin
         model_cnt = 32'hFFFF_FFFE;
         force_ack = force_req;
      end
      if (!rstn) begin
         mon_ridx  = drv_widx;
         model_cnt = 32'd0;
         pend_cnt  = 1'b0;
      end else if (sample_en) begin
         checkOutput("strobe_src", 32'(mon_ridx < drv_widx), 32'd1);
         checkOutput("sample_data", {30'd0, sign, mag}, {30'd0, drv_mem[mon_ridx % DRV_N]});
         mon_ridx++;
         model_cnt = model_cnt + 32'd1;
         pend_cnt  = 1'b1;
      end else if (pend_cnt) begin
         checkOutput("sample_count", sample_count, model_cnt);
         pend_cnt = 1'b0;
      end
   end

   task automatic applyStimulus(input int mode, input bit run, input bit hold);
      @(negedge correlator_clk);
      #1;
      data_mode = mode;
      if_run    = run;
      hold_high = hold;
   endtask

   task automatic wait_strobe(input string tag, output int cycles);
      cycles = 0;
      do begin
         @(negedge correlator_clk);
         cycles++;
      end while (!sample_en && cycles < 300);
      if (!sample_en) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_lost(input string tag);
      int n;
      n = 0;
      while (!clk_lost && n < 400) begin
         @(negedge correlator_clk);
         n++;
      end
      if (!clk_lost) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_samples(input int first, input int count);
      int n;
      n = 0;
      while ((mon_ridx - first) < count && n < 3000) begin
         @(negedge correlator_clk);
         n++;
      end
      if ((mon_ridx - first) < count) checkOutput("wait_samples_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int first);
      int n;
      n = 0;
      while (!snap_done && n < 4000) begin
         @(negedge correlator_clk);
         n++;
      end
      checkOutput("done_seen", snap_done, 1'b1);
      checkOutput("done_after_256", mon_ridx - first, 32'd256);
      checkOutput("busy_after_done", snap_busy, 1'b0);
      checkOutput("err_after_done", snap_err, 1'b0);
   endtask

   // Requests land well clear of any strobe so the first captured sample is known exactly
   task automatic start_snapshot(input bit align, output int first);
      int c;
      int tries;
      tries = 0;
      if (align) repeat (3) wait_strobe("align", c);
      do begin
         wait_strobe("pre_start", c);
         @(negedge correlator_clk);
         @(negedge correlator_clk);
         tries++;
      end while (align && (mon_ridx % 4) != 0 && tries < 8);
      snap_start = 1'b1;
      first = mon_ridx;
      @(negedge correlator_clk);
      snap_start = 1'b0;
      checkOutput("busy_after_start", snap_busy, 1'b1);
      checkOutput("err_after_start", snap_err, 1'b0);
      checkOutput("done_after_start", snap_done, 1'b0);
   endtask

   task automatic read_word(input int addr, output logic [31:0] data);
      @(negedge correlator_clk);
      snap_rd_addr = SNAP_AW'(addr);
      @(negedge correlator_clk);
      data = snap_rd_data;
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_sign_mag_en"}, {29'd0, sign, mag, sample_en}, 32'd0);
      checkOutput({tag, "_count"}, sample_count, 32'd0);
      checkOutput({tag, "_lost"}, clk_lost, 1'b0);
      checkOutput({tag, "_snap_flags"}, {29'd0, snap_busy, snap_done, snap_err}, 32'd0);
      checkOutput({tag, "_rd_data"}, snap_rd_data, 32'd0);
   endtask

   initial begin
      int          cyc_n;
      int          n;
      int          first;
      logic [31:0] word;

      rstn         = 1'b0;
      snap_start   = 1'b0;
      snap_rd_addr = '0;
      repeat (3) @(negedge correlator_clk);
      check_all_zero("reset");
      rstn = 1'b1;

      // Constant (1,0) samples at corr/8
      applyStimulus(2, 1'b1, 1'b0);
      wait_strobe("first_strobe", cyc_n);
      checkOutput("first_latency", 32'((cyc_n - 1) >= SYNC_STAGES && (cyc_n - 1) <= SYNC_STAGES + 2), 32'd1);
      checkOutput("first_sign_mag", {30'd0, sign, mag}, 32'd2);
      @(negedge correlator_clk);
      checkOutput("count_seq", sample_count, 32'd1);
      for (int i = 2; i <= 6; i++) begin
         wait_strobe("strobe", cyc_n);
         checkOutput("strobe_gap", cyc_n + 1, 32'd8);
         checkOutput("sign_mag_const", {30'd0, sign, mag}, 32'd2);
         @(negedge correlator_clk);
         checkOutput("count_seq", sample_count, 32'(i));
         checkOutput("en_one_cycle", sample_en, 1'b0);
      end
      checkOutput("lost_while_running", clk_lost, 1'b0);

      // Watchdog: if_clk held high
      applyStimulus(0, 1'b1, 1'b1);
      n = 0;
      do begin
         @(negedge correlator_clk);
         n++;
         if (sample_en) n = 0;
      end while (!clk_lost && n < 300);
      checkOutput("clk_lost_delay", n, 32'(WDOG_LIMIT + 1));
      snap_start = 1'b1;
      @(negedge correlator_clk);
      snap_start = 1'b0;
      checkOutput("start_ignored_when_lost", snap_busy, 1'b0);
      applyStimulus(0, 1'b1, 1'b0);
      wait_strobe("restart", cyc_n);
      checkOutput("lost_at_restart", clk_lost, 1'b1);
      @(negedge correlator_clk);
      checkOutput("lost_cleared", clk_lost, 1'b0);

      // Abort after 40 samples, partial buffer kept
      start_snapshot(1'b0, first);
      wait_samples(first, 40);
      applyStimulus(0, 1'b1, 1'b1);
      wait_lost("abort_lost");
      @(negedge correlator_clk);
      checkOutput("abort_err", snap_err, 1'b1);
      checkOutput("abort_done", snap_done, 1'b0);
      checkOutput("abort_busy", snap_busy, 1'b0);
      for (int w = 0; w < 2; w++) begin
         read_word(w, word);
         checkOutput("partial_word", word, model_word(first, w));
      end
      applyStimulus(0, 1'b1, 1'b0);
      wait_strobe("rearm", cyc_n);
      @(negedge correlator_clk);
      checkOutput("lost_cleared2", clk_lost, 1'b0);

      // Full random snapshot with an ignored mid-capture request
      start_snapshot(1'b0, first);
      wait_samples(first, 100);
      snap_start = 1'b1;
      @(negedge correlator_clk);
      snap_start = 1'b0;
      checkOutput("busy_mid_capture", snap_busy, 1'b1);
      wait_done(first);
      for (int w = 0; w < NWORDS; w++) begin
         read_word(w, word);
         checkOutput("random_word", word, model_word(first, w));
      end

      // Repeating (1,0),(0,1),(1,1),(0,0) pattern
      applyStimulus(1, 1'b1, 1'b0);
      start_snapshot(1'b1, first);
      wait_done(first);
      for (int w = 0; w < NWORDS; w++) begin
         read_word(w, word);
         checkOutput("pattern_word", word, 32'h9C9C_9C9C);
      end

      // Reset in the middle of a capture
      applyStimulus(0, 1'b1, 1'b0);
      start_snapshot(1'b0, first);
      wait_samples(first, 50);
      applyStimulus(0, 1'b0, 1'b0);
      repeat (12) @(negedge correlator_clk);
      checkOutput("busy_before_reset", snap_busy, 1'b1);
      rstn = 1'b0;
      @(negedge correlator_clk);
      check_all_zero("mid_reset");
      @(negedge correlator_clk);
      rstn = 1'b1;
      @(negedge correlator_clk);
      checkOutput("idle_after_reset", {30'd0, snap_busy, snap_done}, 32'd0);
      applyStimulus(0, 1'b1, 1'b0);
      wait_strobe("post_reset", cyc_n);
      @(negedge correlator_clk);
      checkOutput("count_after_reset", sample_count, 32'd1);

      // Counter wrap
      applyStimulus(0, 1'b0, 1'b0);
      repeat (12) @(negedge correlator_clk);
      force dut.sample_count = 32'hFFFF_FFFE;
      force_req++;
      @(negedge correlator_clk);
      release dut.sample_count;
      @(negedge correlator_clk);
      applyStimulus(0, 1'b1, 1'b0);
      wait_strobe("wrap1", cyc_n);
      wait_strobe("wrap2", cyc_n);
      @(negedge correlator_clk);
      checkOutput("count_wrap", sample_count, 32'd0);

      applyStimulus(0, 1'b0, 1'b0);
      repeat (12) @(negedge correlator_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: got still running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
